cpu_trace_buffer: RTL

//  Synthesizable execution tracer for cpu_synth. Snoops the stage counter, the fetched instruction
//  and the write-back value, and stores them as tagged entries in a DEPTH-entry ring buffer.

---
 rtl/cpu_trace_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - execution tracer: stage-tagged capture into a ring buffer with trigger/freeze
module cpu_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int STAGE_W   = 3,
    parameter int DEPTH     = 16,
    parameter int FETCH_STG = 1,
    parameter int WB_STG    = 4,
    parameter int POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STAGE_W-1:0]       i_stage,
    input  logic [DATA_W-1:0]        i_instr,
    input  logic [DATA_W-1:0]        i_wb_data,
    input  logic                     i_enable,
    input  logic                     i_clear,
    input  logic                     i_trig_en,
    input  logic [DATA_W-1:0]        i_trig_instr,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [STAGE_W-1:0]       o_rd_tag,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_triggered,
    output logic                     o_frozen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(POST_TRIG + 2);
    localparam bit ZERO_POST = (POST_TRIG == 0);

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic [STAGE_W-1:0]  mem_tag  [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [PW-1:0]       post;
    logic                overflow, triggered;

    logic                is_fetch, is_wb, post_done, capture, trig_hit, pop, full;
    logic [DATA_W-1:0]   cap_data;

    assign is_fetch  = (i_stage == STAGE_W'(FETCH_STG));
    assign is_wb     = (i_stage == STAGE_W'(WB_STG));
    // Once the post-trigger budget is spent, nothing more is stored while waiting to freeze.
    assign post_done = triggered && (post == '0);
    assign capture   = (state == RUN) && (is_fetch || is_wb) && !post_done;
    assign trig_hit  = capture && is_fetch && i_trig_en && !triggered && (i_instr == i_trig_instr);
    assign pop       = (count != '0) && i_rd_ready;
    assign full      = (count == CW'(DEPTH));
    assign cap_data  = is_fetch ? i_instr : i_wb_data;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_enable) state_nxt = RUN;
            RUN: begin
                if (!i_enable)
                    state_nxt = IDLE;
                else if ((trig_hit && ZERO_POST) || post_done)
                    state_nxt = FROZEN;
            end
            FROZEN:  if (!i_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_clear)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post      <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
        end else if (i_clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post      <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
        end else begin
            if (capture)
                wr_ptr <= wr_ptr + AW'(1);
            // A full-buffer capture without a pop drops the oldest entry.
            if (pop || (capture && full))
                rd_ptr <= rd_ptr + AW'(1);
            if (capture && !pop && !full)
                count <= count + CW'(1);
            else if (!capture && pop)
                count <= count - CW'(1);
            if (capture && !pop && full)
                overflow <= 1'b1;
            if (trig_hit) begin
                triggered <= 1'b1;
                post      <= PW'(POST_TRIG);
            end else if (capture && triggered && (post != '0)) begin
                post <= post - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture && !i_clear) begin
            mem_data[wr_ptr] <= cap_data;
            mem_tag[wr_ptr]  <= i_stage;
        end
    end

    assign o_rd_valid  = (count != '0);
    assign o_rd_data   = o_rd_valid ? mem_data[rd_ptr] : '0;
    assign o_rd_tag    = o_rd_valid ? mem_tag[rd_ptr]  : '0;
    assign o_count     = count;
    assign o_overflow  = overflow;
    assign o_triggered = triggered;
    assign o_frozen    = (state == FROZEN);
endmodule
